// File: rtl/jtag_tap_param.sv
// IEEE 1149.1-style TAP controller with a programmable IR, BYPASS, IDCODE and one user DR.
// Optional feature: define TAP_TRST_EN to add the trst_n port, which is ORed with rst.
module jtag_tap_param #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned IDCODE_OP  = 1,
  parameter int unsigned USER_OP    = 2
) (
  input  logic                  tck,
  input  logic                  rst,
`ifdef TAP_TRST_EN
  input  logic                  trst_n,
`endif
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_upd,
  output logic [3:0]            tap_state
);

  localparam logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] USER_IR    = IR_WIDTH'(USER_OP);
  localparam logic [IR_WIDTH-1:0] IR_ONES    = {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  if (IR_WIDTH < 2) begin : g_chk_ir_width
    $error("jtag_tap_param: IR_WIDTH must be at least 2");
  end
  if (USER_WIDTH < 1) begin : g_chk_user_width
    $error("jtag_tap_param: USER_WIDTH must be at least 1");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_chk_idcode_lsb
    $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
  end
  if ((USER_IR == IDCODE_IR) || (USER_IR == IR_ONES)) begin : g_chk_user_op
    $error("jtag_tap_param: USER_OP must differ from IDCODE_OP and from all-ones");
  end

  typedef enum logic [3:0] {
    TLR     = 4'd0,
    RTI     = 4'd1,
    SEL_DR  = 4'd2,
    CAP_DR  = 4'd3,
    SH_DR   = 4'd4,
    EX1_DR  = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR  = 4'd7,
    UPD_DR  = 4'd8,
    SEL_IR  = 4'd9,
    CAP_IR  = 4'd10,
    SH_IR   = 4'd11,
    EX1_IR  = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR  = 4'd14,
    UPD_IR  = 4'd15
  } tap_state_e;

  function automatic tap_state_e next_state(input tap_state_e s, input logic t);
    case (s)
      TLR:      return t ? TLR    : RTI;
      RTI:      return t ? SEL_DR : RTI;
      SEL_DR:   return t ? SEL_IR : CAP_DR;
      CAP_DR:   return t ? EX1_DR : SH_DR;
      SH_DR:    return t ? EX1_DR : SH_DR;
      EX1_DR:   return t ? UPD_DR : PAUSE_DR;
      PAUSE_DR: return t ? EX2_DR : PAUSE_DR;
      EX2_DR:   return t ? UPD_DR : SH_DR;
      UPD_DR:   return t ? SEL_DR : RTI;
      SEL_IR:   return t ? TLR    : CAP_IR;
      CAP_IR:   return t ? EX1_IR : SH_IR;
      SH_IR:    return t ? EX1_IR : SH_IR;
      EX1_IR:   return t ? UPD_IR : PAUSE_IR;
      PAUSE_IR: return t ? EX2_IR : PAUSE_IR;
      EX2_IR:   return t ? UPD_IR : SH_IR;
      UPD_IR:   return t ? SEL_DR : RTI;
      default:  return TLR;
    endcase
  endfunction

  // Right shift with the serial input entering the MSB; written to stay legal for width 1.
  function automatic logic [USER_WIDTH-1:0] shift_user(input logic [USER_WIDTH-1:0] v,
                                                       input logic b);
    logic [USER_WIDTH:0] ext;
    ext = {b, v};
    return ext[USER_WIDTH:1];
  endfunction

  tap_state_e            state_r;
  tap_state_e            state_nxt_s;
  logic [IR_WIDTH-1:0]   ir_r;
  logic [IR_WIDTH-1:0]   ir_sr_r;
  logic [31:0]           id_sr_r;
  logic [USER_WIDTH-1:0] user_sr_r;
  logic                  byp_r;
  logic [USER_WIDTH-1:0] user_out_r;
  logic                  user_upd_r;
  logic                  reset_s;
  logic                  sel_id_s;
  logic                  sel_user_s;
  logic                  tdo_s;

`ifdef TAP_TRST_EN
  assign reset_s = rst | ~trst_n;
`else
  assign reset_s = rst;
`endif

  assign state_nxt_s = next_state(state_r, tms);
  assign sel_id_s    = (ir_r == IDCODE_IR);
  assign sel_user_s  = (ir_r == USER_IR);

  // Serial output mux: LSB of whichever register is currently shifting.
  always_comb begin
    tdo_s = 1'b0;
    if (state_r == SH_IR) begin
      tdo_s = ir_sr_r[0];
    end else if (state_r == SH_DR) begin
      if (sel_id_s) begin
        tdo_s = id_sr_r[0];
      end else if (sel_user_s) begin
        tdo_s = user_sr_r[0];
      end else begin
        tdo_s = byp_r;
      end
    end else begin
      tdo_s = 1'b0;
    end
  end

  // TAP state machine with capture/shift/update actions keyed on the current state.
  always_ff @(posedge tck) begin
    if (reset_s) begin
      state_r    <= TLR;
      ir_r       <= IDCODE_IR;
      ir_sr_r    <= '0;
      id_sr_r    <= 32'h0000_0000;
      user_sr_r  <= '0;
      byp_r      <= 1'b0;
      user_out_r <= '0;
      user_upd_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      user_upd_r <= 1'b0;
      case (state_r)
        CAP_IR: ir_sr_r <= IR_CAPTURE;
        SH_IR:  ir_sr_r <= {tdi, ir_sr_r[IR_WIDTH-1:1]};
        UPD_IR: ir_r    <= ir_sr_r;
        CAP_DR: begin
          if (sel_id_s) begin
            id_sr_r <= IDCODE_VAL;
          end else if (sel_user_s) begin
            user_sr_r <= user_in;
          end else begin
            byp_r <= 1'b0;
          end
        end
        SH_DR: begin
          if (sel_id_s) begin
            id_sr_r <= {tdi, id_sr_r[31:1]};
          end else if (sel_user_s) begin
            user_sr_r <= shift_user(user_sr_r, tdi);
          end else begin
            byp_r <= tdi;
          end
        end
        UPD_DR: begin
          if (sel_user_s) begin
            user_out_r <= user_sr_r;
            user_upd_r <= 1'b1;
          end else begin
            user_upd_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      // Test-Logic-Reset always leaves IDCODE selected, however it was reached.
      if (state_nxt_s == TLR) begin
        ir_r <= IDCODE_IR;
      end else begin
      end
    end
  end

  assign tdo       = tdo_s;
  assign tdo_en    = (state_r == SH_IR) || (state_r == SH_DR);
  assign user_out  = user_out_r;
  assign user_upd  = user_upd_r;
  assign tap_state = state_r;

endmodule
